button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, number of button inputs (2..16).
REQ-002 The block SHALL have parameter DB_CYCLES, default 1000, consecutive stable samples required to accept a level change (1..65535).
REQ-003 The block SHALL have derived parameter IDW = max(1, clog2(N_BTN)), the width of the event index.
REQ-004 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1, synchronous active-low reset.
REQ-006 Port button, input, N_BTN, raw asynchronous button levels, active-high.
REQ-007 Port evt_valid, output, 1, an event is presented.
REQ-008 Port evt_ready, input, 1, consumer accepts the event; transfer occurs when evt_valid && evt_ready.
REQ-009 Port evt_id, output, IDW, index of the button whose press is presented.
REQ-010 Port evt_overrun, output, 1, one-cycle pulse: a press was lost because that button's event was still pending.

Function
REQ-011 Each button bit SHALL pass a two-flop synchronizer before any other use.
REQ-012 Per button, a debounce counter SHALL count consecutive cycles where the synchronized level differs from the debounced level; the debounced level SHALL take the new value when the count reaches DB_CYCLES; any matching sample SHALL clear the counter.
REQ-013 A 0->1 transition of a debounced level SHALL set pending[i] on the next clock edge.
REQ-014 Latency from a clean raw rising edge to pending[i] set SHALL be 2 + DB_CYCLES + 1 cycles; evt_valid SHALL assert one cycle later if the output stage is idle.
REQ-015 The output stage SHALL be a two-state FSM: IDLE (evt_valid=0) and PRESENT (evt_valid=1).
REQ-016 IDLE->PRESENT when any pending bit is set: the block SHALL select the first set bit in round-robin order starting at (last_grant+1) mod N_BTN, load evt_id, and clear that pending bit.
REQ-017 In PRESENT, evt_valid and evt_id SHALL hold stable until evt_ready is high.
REQ-018 On a transfer, if another pending bit is set, the FSM SHALL stay in PRESENT and load the next round-robin winner in the same edge (back-to-back, one event per cycle); otherwise it SHALL return to IDLE.
REQ-019 last_grant SHALL update only when a new event is loaded; its reset value SHALL be N_BTN-1 so button 0 wins first.
REQ-020 A new edge on button i while pending[i] is already set SHALL leave pending[i] set and pulse evt_overrun for one cycle.
REQ-021 A new edge on button i in the same cycle that pending[i] is cleared by selection SHALL leave pending[i] set; no overrun.
REQ-022 A button already held through reset SHALL generate exactly one event after DB_CYCLES + 3 cycles.

Reset
REQ-023 While rst_n=0, at each clock edge: synchronizers, debounced levels, counters, and pending SHALL be 0; FSM SHALL be IDLE; evt_valid=0, evt_id=0, evt_overrun=0; last_grant=N_BTN-1.
REQ-024 Reset asserted mid-handshake SHALL discard the presented event and all pending events, with no partial output.

Configuration
REQ-025 With macro BTN_DEBOUNCE_EN defined, debounce SHALL operate per REQ-012.
REQ-026 Without BTN_DEBOUNCE_EN, counters SHALL be omitted, the debounced level SHALL equal the synchronized level, and REQ-014 latency SHALL be 3 cycles; DB_CYCLES SHALL be ignored.

Structure
REQ-027 Package btn_pkg SHALL hold the FSM state typedef (IDLE, PRESENT), the N_BTN default, and the IDW derivation function.
REQ-028 Per-button logic (synchronizer, debounce, rising-edge pulse) SHALL be sub-module btn_debounce, instantiated N_BTN times.
REQ-029 The arbiter and output FSM SHALL reside in button_event_arbiter.

Verification (DB_CYCLES=4, N_BTN=4, BTN_DEBOUNCE_EN defined unless stated)
REQ-030 Scenario: button[2] rises clean, evt_ready=1 -> evt_valid high 8 cycles later for 1 cycle with evt_id=2.
REQ-031 Scenario: button[1] toggles every 2 cycles for 20 cycles, then settles high -> exactly one event with id 1, no event during bounce.
REQ-032 Scenario: buttons 0..3 press in the same cycle, evt_ready=0 for 10 cycles then 1 -> ids 0,1,2,3 on consecutive cycles; evt_id stable while stalled.
REQ-033 Scenario: button 3 pressed twice while evt_ready=0 and id 3 is pending -> one evt_overrun pulse; one id-3 event delivered.
REQ-034 Scenario: rst_n low for 1 cycle while evt_valid=1 -> evt_valid=0 next cycle and pending cleared; held buttons re-fire per REQ-022.
REQ-035 Scenario: BTN_DEBOUNCE_EN undefined, button[0] rises -> evt_valid with id 0 four cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the button event arbiter.
// The state encoding is also used by any block that snoops the output stage.
package btn_pkg;

    localparam int N_BTN_DEF = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

    // Event index width; a single button still needs one bit of id
    function automatic int idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button front end: two-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce counter is only built when BTN_DEBOUNCE_EN is defined.
module btn_debounce #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic [1:0] sync_q;
    logic       level;
    logic       level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], raw};
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int             CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          db_q;
    logic [CW-1:0] cnt_q;

    // Counter tracks consecutive disagreeing samples; the level flips on the
    // DB_CYCLES-th one, so it never has to hold DB_CYCLES itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else if (sync_q[1] == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            db_q  <= sync_q[1];
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = db_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) level_d <= 1'b0;
        else        level_d <= level;
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button presses queued as pending bits and presented one at a time,
// round-robin, over a valid/ready port. Debounce enabled by BTN_DEBOUNCE_EN.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter  int N_BTN     = N_BTN_DEF,
    parameter  int DB_CYCLES = 1000,
    localparam int IDW       = idw(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDW-1:0]   evt_id,
    output logic             evt_overrun
);

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] pend_d;
    logic [N_BTN-1:0] clr;
    logic             ovr_d;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   win_lo;
    logic [IDW-1:0]   win_hi;
    logic             found_hi;
    logic             any_pend;
    logic             load;
    arb_state_t       state_q;
    arb_state_t       state_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (button[i]),
            .rise (rise[i])
        );
    end

    // Round-robin pick: lowest pending index above last_grant, else wrap to
    // the lowest pending index overall. Descending scan leaves the lowest hit.
    always_comb begin
        win_lo   = '0;
        win_hi   = '0;
        found_hi = 1'b0;
        for (int j = N_BTN - 1; j >= 0; j--) begin
            if (pending[j]) begin
                win_lo = IDW'(j);
                if (j > int'(last_grant)) begin
                    win_hi   = IDW'(j);
                    found_hi = 1'b1;
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    assign any_pend = |pending;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    if (any_pend) load    = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A press landing on the same edge its pending bit is consumed re-arms it;
    // only a press on a bit that stays pending counts as lost.
    always_comb begin
        clr = '0;
        if (load) clr[win] = 1'b1;
        pend_d = (pending & ~clr) | rise;
        ovr_d  = |(rise & pending & ~clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending     <= '0;
            evt_id      <= '0;
            evt_overrun <= 1'b0;
            last_grant  <= IDW'(N_BTN - 1);
        end else begin
            state_q     <= state_d;
            pending     <= pend_d;
            evt_overrun <= ovr_d;
            if (load) begin
                evt_id     <= win;
                last_grant <= win;
            end
        end
    end

    assign evt_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N_BTN=4, DB_CYCLES=4); expectations
// follow BTN_DEBOUNCE_EN so the same bench serves both builds.
module tb_button_event_arbiter;

    localparam int N  = 4;
    localparam int DB = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int D          = DB;
    localparam int EXP_BOUNCE = 1;
    localparam int EXP_MID    = 0;
`else
    localparam int D          = 0;
    localparam int EXP_BOUNCE = 6;
    localparam int EXP_MID    = 4;
`endif
    // raw press -> evt_valid, counted in rising edges
    localparam int LAT = D + 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] button;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic         evt_overrun;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    logic [1:0] log_q[$];

    button_event_arbiter #(.N_BTN(N), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_overrun(evt_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values equal the
    // values seen at the following posedge.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) log_q.push_back(evt_id);
        if (evt_overrun) ovr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int base;
        int ovr_base;
        int bad;

        rst_n = 1'b0;
        button = '0;
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_ovr", evt_overrun, 0);
        rst_n = 1'b1;
        tick();

        // single clean press, consumer ready
        base = log_q.size();
        button = 4'b0100;
        repeat (LAT - 1) tick();
        chk("s1_early_valid", evt_valid, 0);
        tick();
        chk("s1_valid", evt_valid, 1);
        chk("s1_id", evt_id, 2);
        tick();
        chk("s1_valid_drop", evt_valid, 0);
        chk("s1_count", log_q.size() - base, 1);
        button = '0;
        repeat (12) tick();

        // bouncing button 1, then settles high
        base = log_q.size();
        ovr_base = ovr_cnt;
        for (int c = 0; c < 20; c++) begin
            button[1] = ((c / 2) % 2 == 0);
            tick();
        end
        chk("s2_mid_count", log_q.size() - base, EXP_MID);
        button[1] = 1'b1;
        repeat (LAT + 6) tick();
        chk("s2_count", log_q.size() - base, EXP_BOUNCE);
        bad = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i] != 2'd1) bad++;
        chk("s2_ids", bad, 0);
        chk("s2_ovr", ovr_cnt - ovr_base, 0);
        button = '0;
        repeat (12) tick();

        // simultaneous presses under backpressure, from fresh arbitration state
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base = log_q.size();
        evt_ready = 1'b0;
        button = 4'b1111;
        repeat (LAT) tick();
        chk("s3_valid", evt_valid, 1);
        chk("s3_id0", evt_id, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("s3_stall_valid", evt_valid, 1);
            chk("s3_stall_id", evt_id, 0);
        end
        evt_ready = 1'b1;
        tick();
        chk("s3_id1", evt_id, 1);
        chk("s3_valid1", evt_valid, 1);
        tick();
        chk("s3_id2", evt_id, 2);
        tick();
        chk("s3_id3", evt_id, 3);
        chk("s3_valid3", evt_valid, 1);
        tick();
        chk("s3_idle", evt_valid, 0);
        chk("s3_count", log_q.size() - base, 4);
        for (int i = 0; i < 4 && base + i < log_q.size(); i++)
            chk("s3_order", log_q[base + i], i);
        button = '0;
        repeat (12) tick();

        // overrun: button 3 re-pressed while its event is still pending
        base = log_q.size();
        ovr_base = ovr_cnt;
        evt_ready = 1'b0;
        button = 4'b0001;
        repeat (LAT) tick();
        chk("s4_hold_id", evt_id, 0);
        button = 4'b1001;
        repeat (LAT) tick();
        button = 4'b0001;
        repeat (12) tick();
        chk("s4_no_ovr_yet", ovr_cnt - ovr_base, 0);
        button = 4'b1001;
        repeat (LAT - 1) tick();
        chk("s4_ovr_pulse", evt_overrun, 1);
        tick();
        chk("s4_ovr_end", evt_overrun, 0);
        evt_ready = 1'b1;
        tick();
        chk("s4_valid3", evt_valid, 1);
        chk("s4_id3", evt_id, 3);
        tick();
        chk("s4_idle", evt_valid, 0);
        chk("s4_count", log_q.size() - base, 2);
        if (log_q.size() - base == 2) begin
            chk("s4_first", log_q[base], 0);
            chk("s4_second", log_q[base + 1], 3);
        end
        chk("s4_ovr_count", ovr_cnt - ovr_base, 1);
        button = '0;
        repeat (12) tick();

        // reset mid-handshake with buttons held through it
        base = log_q.size();
        evt_ready = 1'b0;
        button = 4'b0110;
        repeat (LAT) tick();
        chk("s5_valid", evt_valid, 1);
        chk("s5_id", evt_id, 1);
        rst_n = 1'b0;
        tick();
        chk("s5_rst_valid", evt_valid, 0);
        chk("s5_rst_id", evt_id, 0);
        rst_n = 1'b1;
        tick();
        chk("s5_post_valid", evt_valid, 0);
        repeat (LAT - 2) tick();
        chk("s5_refire_early", evt_valid, 0);
        tick();
        chk("s5_refire_valid", evt_valid, 1);
        chk("s5_refire_id", evt_id, 1);
        evt_ready = 1'b1;
        tick();
        chk("s5_next_id", evt_id, 2);
        tick();
        chk("s5_idle", evt_valid, 0);
        chk("s5_count", log_q.size() - base, 2);
        button = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
